controller_pio_pulse: RTL and testbench
=======================================

# controller_pio_pulse

Parametrised Avalon-MM output PIO for the controller subsystem: a DATA_WIDTH-bit output register with atomic SET/CLEAR/TOGGLE write ports, plus a hardware one-shot pulse engine that raises selected bits for a programmed number of clock cycles and clears them automatically. It replaces the fixed-width set/clear output PIOs, so firmware can drive strobes and kicker/solenoid enables with cycle-exact widths without software timing. It sits on the controller's Avalon bus as a zero-wait-state slave.

## Interface
- DATA_WIDTH, 10, width of out_port and of all data registers (1..32)
- CNT_WIDTH, 16, width of pulse-length register and down-counter (1..32)
- RESET_VALUE, 0, out_port value after reset
- PULSE_DEFAULT, 1000, PULSE_LEN value after reset (cycles)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- address  in  3  word register index
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; write = chipselect & ~write_n
- writedata  in  32  write data; bits above the register width ignored
- readdata  out  32  combinational read data, zero-extended
- out_port  out  DATA_WIDTH  output register
- irq  out  1  pulse-done interrupt, level, registered

## Operation
- Registers (write effect / read value):
  - 0 DATA: out_port <= writedata; pulse cancelled (mask 0, busy 0, done unchanged). Read: out_port.
  - 1 STATUS: write bit1=1 clears done; write bit2 sets irq_en. Read: {29'b0, irq_en, done, busy}.
  - 2 PULSE_LEN: loads length; value 0 stored as 1. Read: PULSE_LEN.
  - 3 PULSE: out_port |= w; mask |= w; counter <= PULSE_LEN; busy <= 1 if w≠0 (w=0 ignored). Read: current mask.
  - 4 SET: out_port |= w. Read 0.
  - 5 CLEAR: out_port &= ~w; mask &= ~w; if mask becomes 0, busy <= 0, no done. Read 0.
  - 6 TOGGLE: out_port ^= w; mask unchanged. Read 0.
  - 7 reserved: write ignored, read 0.
- Pulse engine: while busy, counter decrements every cycle; on the cycle counter==1 ("expire"): out_port &= ~mask, mask <= 0, busy <= 0, done <= 1.
- Retrigger: PULSE write while busy ORs new bits into mask and reloads counter; all masked bits end together at new expiry.
- Simultaneous expire + bus write: expiry applied first, bus write applied to the result (bus wins on out_port); PULSE write in the expire cycle starts a fresh pulse with only the new bits, done still set.
- Simultaneous done-set and STATUS clear: done stays 1.
- irq = done & irq_en, registered.
- Reset: out_port=RESET_VALUE, mask=0, counter=0, busy=0, done=0, irq_en=0, irq=0, PULSE_LEN=PULSE_DEFAULT; mid-pulse reset abandons the pulse immediately.

## Timing
- Writes take effect at the rising edge with write asserted; out_port updates that edge.
- readdata combinational from address and current registers; zero wait states, read latency 0.
- PULSE written at edge k with PULSE_LEN=N: bits high from edge k through edge k+N, cleared at edge k+N (exactly N cycles high); done=1 at edge k+N; irq=1 at edge k+N+1.
- Retrigger at edge j: bits cleared at edge j+N.
- Counter width CNT_WIDTH, no wrap: loaded only by PULSE write, stops at expiry.

## Structure
- Package controller_pio_pkg: register address constants (ADDR_DATA..ADDR_RSVD), STATUS bit indices.
- Sub-module controller_pio_pulse_timer: counter, busy, load/cancel inputs, single-cycle expire output.
- Top: bus decode, out_port/mask/done/irq_en registers, read mux.

## Test plan
- Reset with RESET_VALUE=0x155 -> out_port=0x155, readdata@2 = 1000, STATUS=0, irq=0.
- DATA 0x000, SET 0x00F, CLEAR 0x003, TOGGLE 0x301 -> out_port 0x00F, 0x00C, 0x30D.
- PULSE_LEN=5, PULSE 0x010 -> out_port bit4 high exactly 5 cycles; STATUS busy during, done=1 after; with irq_en, irq one cycle after done; STATUS write 0x2 clears done/irq.
- PULSE 0x001, 3 cycles later PULSE 0x002 (len 5) -> both bits clear together 5 cycles after second write; mask reads 0x003 in between.
- PULSE_LEN=0 -> pulse lasts 1 cycle; SET 0x001 in the expire cycle of a 0x001 pulse -> bit stays 1.
- Reset asserted mid-pulse -> out_port=RESET_VALUE immediately, busy=0, no done after release.

Source files
------------

// File: rtl/controller_pio_pkg.sv
// Register map and STATUS field positions for the controller output PIO.
package controller_pio_pkg;

   localparam int unsigned ADDR_WIDTH = 3;
   localparam int unsigned BUS_WIDTH  = 32;

   localparam logic [ADDR_WIDTH-1:0] ADDR_DATA      = 3'd0;
   localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS    = 3'd1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_PULSE_LEN = 3'd2;
   localparam logic [ADDR_WIDTH-1:0] ADDR_PULSE     = 3'd3;
   localparam logic [ADDR_WIDTH-1:0] ADDR_SET       = 3'd4;
   localparam logic [ADDR_WIDTH-1:0] ADDR_CLEAR     = 3'd5;
   localparam logic [ADDR_WIDTH-1:0] ADDR_TOGGLE    = 3'd6;
   localparam logic [ADDR_WIDTH-1:0] ADDR_RSVD      = 3'd7;

   localparam int unsigned ST_BUSY   = 0;
   localparam int unsigned ST_DONE   = 1;
   localparam int unsigned ST_IRQ_EN = 2;

endpackage

// File: rtl/controller_pio_pulse_timer.sv
// One-shot down-counter: load starts/retriggers, cancel abandons, expire_c marks the last cycle.
module controller_pio_pulse_timer #(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] len,
   input  logic                 cancel,
   output logic                 busy,
   output logic                 expire_c
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 busy_q, busy_d;

   assign expire_c = busy_q && (cnt_q == CNT_WIDTH'(1));
   assign busy     = busy_q;

   // Load wins over expiry so a PULSE write in the expire cycle starts a fresh pulse.
   always_comb begin
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (load) begin
         cnt_d  = len;
         busy_d = 1'b1;
      end else if (cancel || expire_c) begin
         cnt_d  = '0;
         busy_d = 1'b0;
      end else if (busy_q) begin
         cnt_d = cnt_q - CNT_WIDTH'(1);
      end
   end

   // Counter and busy state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/controller_pio_pulse.sv
// Avalon-MM output PIO with SET/CLEAR/TOGGLE ports and a hardware one-shot pulse engine.
module controller_pio_pulse
   import controller_pio_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 10,
   parameter int unsigned CNT_WIDTH     = 16,
   parameter int unsigned RESET_VALUE   = 0,
   parameter int unsigned PULSE_DEFAULT = 1000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  irq
);

   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic [DATA_WIDTH-1:0] mask_q, mask_d;
   logic [CNT_WIDTH-1:0]  len_q, len_d;
   logic                  done_q, done_d;
   logic                  irq_en_q, irq_en_d;
   logic                  irq_q, irq_d;

   logic                  wr_c;
   logic [DATA_WIDTH-1:0] w_data_c;
   logic [CNT_WIDTH-1:0]  w_len_c;
   logic                  load_c, cancel_c, busy, expire_c;
   logic                  unused_wdata;

   assign wr_c         = chipselect & ~write_n;
   assign w_data_c     = writedata[DATA_WIDTH-1:0];
   assign w_len_c      = writedata[CNT_WIDTH-1:0];
   assign unused_wdata = ^writedata;

   controller_pio_pulse_timer #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (load_c),
      .len      (len_q),
      .cancel   (cancel_c),
      .busy     (busy),
      .expire_c (expire_c)
   );

   // Expiry is applied first, then the bus write acts on the result.
   always_comb begin
      out_d    = out_q;
      mask_d   = mask_q;
      done_d   = done_q;
      irq_en_d = irq_en_q;
      len_d    = len_q;
      load_c   = 1'b0;
      cancel_c = 1'b0;

      if (expire_c) begin
         out_d  = out_q & ~mask_q;
         mask_d = '0;
      end

      // A done-clear racing a fresh expiry loses, so done stays set.
      if (wr_c && (address == ADDR_STATUS) && writedata[ST_DONE]) done_d = 1'b0;
      if (expire_c) done_d = 1'b1;

      if (wr_c) begin
         case (address)
            ADDR_DATA: begin
               out_d    = w_data_c;
               mask_d   = '0;
               cancel_c = 1'b1;
            end
            ADDR_STATUS:    irq_en_d = writedata[ST_IRQ_EN];
            ADDR_PULSE_LEN: len_d = (w_len_c == '0) ? CNT_WIDTH'(1) : w_len_c;
            ADDR_PULSE: begin
               if (w_data_c != '0) begin
                  out_d  = out_d | w_data_c;
                  mask_d = mask_d | w_data_c;
                  load_c = 1'b1;
               end
            end
            ADDR_SET:    out_d = out_d | w_data_c;
            ADDR_CLEAR: begin
               out_d    = out_d & ~w_data_c;
               mask_d   = mask_d & ~w_data_c;
               cancel_c = (mask_d == '0);
            end
            ADDR_TOGGLE: out_d = out_d ^ w_data_c;
            default: ;
         endcase
      end

      irq_d = done_q & irq_en_q;
   end

   // Register state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q    <= DATA_WIDTH'(RESET_VALUE);
         mask_q   <= '0;
         len_q    <= CNT_WIDTH'(PULSE_DEFAULT);
         done_q   <= 1'b0;
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         out_q    <= out_d;
         mask_q   <= mask_d;
         len_q    <= len_d;
         done_q   <= done_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   // Zero-latency read mux.
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:      readdata = BUS_WIDTH'(out_q);
         ADDR_STATUS: begin
            readdata[ST_BUSY]   = busy;
            readdata[ST_DONE]   = done_q;
            readdata[ST_IRQ_EN] = irq_en_q;
         end
         ADDR_PULSE_LEN: readdata = BUS_WIDTH'(len_q);
         ADDR_PULSE:     readdata = BUS_WIDTH'(mask_q);
         default:        readdata = '0;
      endcase
   end

   assign out_port = out_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_controller_pio_pulse.sv
// Directed self-checking bench for controller_pio_pulse.
module tb_controller_pio_pulse;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [9:0]  out_port;
   logic        irq;

   int checks = 0;
   int errors = 0;
   logic [31:0] rd;

   controller_pio_pulse #(
      .DATA_WIDTH    (10),
      .CNT_WIDTH     (16),
      .RESET_VALUE   (32'h155),
      .PULSE_DEFAULT (1000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   // Single write; returns 1ns after the edge at which it took effect.
   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      checks++; if (out_port !== 10'h155) begin errors++; $display("FAIL reset_out got %h exp %h", out_port, 10'h155); end
      bus_read(3'd2, rd);
      checks++; if (rd !== 32'd1000) begin errors++; $display("FAIL reset_len got %0d exp 1000", rd); end
      bus_read(3'd1, rd);
      checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_status got %h exp 0", rd); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
   endtask

   task automatic test_set_clear_toggle();
      bus_write(3'd0, 32'h000);
      checks++; if (out_port !== 10'h000) begin errors++; $display("FAIL data_wr got %h exp 000", out_port); end
      bus_write(3'd4, 32'h00F);
      checks++; if (out_port !== 10'h00F) begin errors++; $display("FAIL set got %h exp 00f", out_port); end
      bus_write(3'd5, 32'h003);
      checks++; if (out_port !== 10'h00C) begin errors++; $display("FAIL clear got %h exp 00c", out_port); end
      bus_write(3'd6, 32'hFFFF_F301);
      checks++; if (out_port !== 10'h30D) begin errors++; $display("FAIL toggle got %h exp 30d", out_port); end
      bus_read(3'd0, rd);
      checks++; if (rd !== 32'h30D) begin errors++; $display("FAIL data_rd got %h exp 30d", rd); end
      bus_read(3'd4, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL set_rd got %h exp 0", rd); end
      bus_write(3'd7, 32'h3FF);
      checks++; if (out_port !== 10'h30D) begin errors++; $display("FAIL rsvd_wr got %h exp 30d", out_port); end
      bus_read(3'd7, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rsvd_rd got %h exp 0", rd); end
   endtask

   task automatic test_pulse();
      bus_write(3'd0, 32'h000);
      bus_write(3'd1, 32'h4);
      bus_write(3'd2, 32'd5);
      bus_read(3'd2, rd);
      checks++; if (rd !== 32'd5) begin errors++; $display("FAIL len_rd got %0d exp 5", rd); end
      bus_write(3'd3, 32'h010);
      for (int i = 0; i < 5; i++) begin
         if (i != 0) tick();
         checks++; if (out_port !== 10'h010) begin errors++; $display("FAIL pulse_high cyc %0d got %h exp 010", i, out_port); end
         bus_read(3'd1, rd);
         checks++; if (rd !== 32'h5) begin errors++; $display("FAIL pulse_busy cyc %0d got %h exp 5", i, rd); end
      end
      tick();
      checks++; if (out_port !== 10'h000) begin errors++; $display("FAIL pulse_end got %h exp 000", out_port); end
      bus_read(3'd1, rd);
      checks++; if (rd !== 32'h6) begin errors++; $display("FAIL pulse_done got %h exp 6", rd); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b exp 0", irq); end
      tick();
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
      bus_write(3'd1, 32'h2);
      bus_read(3'd1, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL done_clr got %h exp 0", rd); end
      tick();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", irq); end

      // DATA write mid-pulse cancels the pulse without done
      bus_write(3'd3, 32'h020);
      bus_write(3'd0, 32'h100);
      bus_read(3'd3, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cancel_mask got %h exp 0", rd); end
      repeat (6) tick();
      bus_read(3'd1, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cancel_status got %h exp 0", rd); end
      checks++; if (out_port !== 10'h100) begin errors++; $display("FAIL cancel_out got %h exp 100", out_port); end
   endtask

   task automatic test_back_to_back();
      bus_write(3'd0, 32'h000);
      bus_write(3'd2, 32'd5);
      bus_write(3'd3, 32'h001);
      repeat (2) tick();
      bus_write(3'd3, 32'h002);
      bus_read(3'd3, rd);
      checks++; if (rd !== 32'h3) begin errors++; $display("FAIL retrig_mask got %h exp 3", rd); end
      for (int i = 1; i < 5; i++) begin
         tick();
         checks++; if (out_port !== 10'h003) begin errors++; $display("FAIL retrig_high cyc %0d got %h exp 003", i, out_port); end
      end
      tick();
      checks++; if (out_port !== 10'h000) begin errors++; $display("FAIL retrig_end got %h exp 000", out_port); end
      bus_read(3'd1, rd);
      checks++; if (rd !== 32'h2) begin errors++; $display("FAIL retrig_done got %h exp 2", rd); end
      bus_write(3'd1, 32'h2);

      // CLEAR of the last masked bit ends the pulse without done
      bus_write(3'd3, 32'h004);
      bus_write(3'd5, 32'h004);
      bus_read(3'd1, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL clr_cancel got %h exp 0", rd); end
      repeat (6) tick();
      bus_read(3'd1, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL clr_nodone got %h exp 0", rd); end
   endtask

   task automatic test_edge_cases();
      bus_write(3'd0, 32'h000);
      bus_write(3'd2, 32'd0);
      bus_read(3'd2, rd);
      checks++; if (rd !== 32'd1) begin errors++; $display("FAIL len_zero got %0d exp 1", rd); end
      bus_write(3'd3, 32'h001);
      checks++; if (out_port !== 10'h001) begin errors++; $display("FAIL min_high got %h exp 001", out_port); end
      tick();
      checks++; if (out_port !== 10'h000) begin errors++; $display("FAIL min_end got %h exp 000", out_port); end
      bus_read(3'd1, rd);
      checks++; if (rd !== 32'h2) begin errors++; $display("FAIL min_done got %h exp 2", rd); end
      bus_write(3'd1, 32'h2);

      // SET in the expire cycle keeps the bit
      bus_write(3'd3, 32'h001);
      bus_write(3'd4, 32'h001);
      checks++; if (out_port !== 10'h001) begin errors++; $display("FAIL set_expire got %h exp 001", out_port); end
      bus_read(3'd1, rd);
      checks++; if (rd !== 32'h2) begin errors++; $display("FAIL set_expire_st got %h exp 2", rd); end
      tick();
      checks++; if (out_port !== 10'h001) begin errors++; $display("FAIL set_expire_hold got %h exp 001", out_port); end

      // STATUS clear in the expire cycle loses to the new done
      bus_write(3'd0, 32'h000);
      bus_write(3'd1, 32'h2);
      bus_write(3'd2, 32'd3);
      bus_write(3'd3, 32'h008);
      repeat (2) tick();
      bus_write(3'd1, 32'h2);
      bus_read(3'd1, rd);
      checks++; if (rd !== 32'h2) begin errors++; $display("FAIL clr_race got %h exp 2", rd); end

      // PULSE in the expire cycle starts fresh with only the new bits
      bus_write(3'd1, 32'h2);
      bus_write(3'd3, 32'h001);
      repeat (2) tick();
      bus_write(3'd3, 32'h002);
      checks++; if (out_port !== 10'h002) begin errors++; $display("FAIL repulse_out got %h exp 002", out_port); end
      bus_read(3'd3, rd);
      checks++; if (rd !== 32'h2) begin errors++; $display("FAIL repulse_mask got %h exp 2", rd); end
      bus_read(3'd1, rd);
      checks++; if (rd !== 32'h3) begin errors++; $display("FAIL repulse_st got %h exp 3", rd); end
      repeat (2) tick();
      checks++; if (out_port !== 10'h002) begin errors++; $display("FAIL repulse_hold got %h exp 002", out_port); end
      tick();
      checks++; if (out_port !== 10'h000) begin errors++; $display("FAIL repulse_end got %h exp 000", out_port); end
   endtask

   task automatic test_reset_mid_pulse();
      bus_write(3'd1, 32'h2);
      bus_write(3'd0, 32'h000);
      bus_write(3'd2, 32'd5);
      bus_write(3'd3, 32'h010);
      tick();
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (out_port !== 10'h155) begin errors++; $display("FAIL rst_mid_out got %h exp 155", out_port); end
      bus_read(3'd1, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mid_status got %h exp 0", rd); end
      bus_read(3'd2, rd);
      checks++; if (rd !== 32'd1000) begin errors++; $display("FAIL rst_mid_len got %0d exp 1000", rd); end
      @(negedge clk);
      reset = 1'b0;
      repeat (8) tick();
      bus_read(3'd1, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_nodone got %h exp 0", rd); end
      checks++; if (out_port !== 10'h155) begin errors++; $display("FAIL rst_hold got %h exp 155", out_port); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
   endtask

   initial begin
      reset      = 1'b1;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      test_reset();
      test_set_clear_toggle();
      test_pulse();
      test_back_to_back();
      test_edge_cases();
      test_reset_mid_pulse();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
